// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and receiver sides.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int UART_CLKS_PER_BIT = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int uart_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for bringing an asynchronous level into the fpga_clk domain.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic fpga_clk,
  input  logic nrst,
  input  logic rst_val,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the flop chain; reset loads the caller's idle level.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      sync_q <= {STAGES{rst_val}};
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits MSB-first, 1 stop bit, no parity.
// Each good frame updates dout with a one-cycle rx_valid; a low stop bit gives
// a one-cycle frame_err and parks the FSM until the line returns to idle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                      fpga_clk,
  input  logic                      nrst,
  input  logic                      sin,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      busy_rx
);

  localparam int HALF_BIT = uart_half_bit(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  rx_state_t state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [2:0]                bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic [UART_DATA_BITS-1:0] dout_nxt;
  logic                      rx_valid_nxt;
  logic                      frame_err_nxt;
  logic                      sin_s;

  uart_sync #(
    .STAGES(2)
  ) u_sin_sync (
    .fpga_clk(fpga_clk),
    .nrst    (nrst),
    .rst_val (UART_IDLE_LEVEL),
    .din     (sin),
    .dout    (sin_s)
  );

  // State, timing counters, shift register and registered output pulses.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      dout      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      dout      <= dout_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Frame sequencing: confirm the start bit at mid-bit, then sample each
  // following bit one full bit period later so every sample lands mid-bit.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    dout_nxt      = dout;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (sin_s != UART_IDLE_LEVEL) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (sin_s != UART_IDLE_LEVEL) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {shreg[UART_DATA_BITS-2:0], sin_s};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (sin_s == UART_IDLE_LEVEL) begin
            dout_nxt     = shreg;
            rx_valid_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BREAK;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      BREAK: begin
        if (sin_s == UART_IDLE_LEVEL) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy_rx = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serializer model drives frames on sin and
// a scoreboard queue holds the pulse expected for each frame sent.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = UART_CLKS_PER_BIT;
  localparam int HALF = CPB / 2;

  logic       fpga_clk = 1'b0;
  logic       nrst     = 1'b0;
  logic       sin      = 1'b1;
  logic [7:0] dout;
  logic       rx_valid;
  logic       frame_err;
  logic       busy_rx;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } sb_item_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         hold_low;
    int         idle_after;
  } vec_t;

  sb_item_t sb_q[$];
  vec_t     vecs[6];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_valid_cyc = -1;
  int         c0;
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  logic gap_track = 1'b0;
  logic gap_counting = 1'b0;
  logic gap_done = 1'b0;
  int   gap_run = 0;
  int   measured_gap = -1;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .fpga_clk (fpga_clk),
    .nrst     (nrst),
    .sin      (sin),
    .dout     (dout),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy_rx  (busy_rx)
  );

  always #5 fpga_clk = ~fpga_clk;

  always @(posedge fpga_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  // Serialize one frame exactly as uart_tx would: start, 8 bits MSB-first, stop.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    sin = 1'b0;
    repeat (CPB) tick();
    for (int i = 7; i >= 0; i--) begin
      sin = data[i];
      repeat (CPB) tick();
    end
    sin = stop_bit;
    repeat (CPB) tick();
  endtask

  // Pop the scoreboard on every output pulse and check pulse spacing rules.
  always @(negedge fpga_clk) begin
    sb_item_t item;
    if (rx_valid || frame_err) begin
      checkOutput("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
      checkOutput("pulse_spacing", 32'(prev_pulse), 32'd0);
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_pulse", 32'({rx_valid, frame_err}), 32'd0);
      end else begin
        item = sb_q.pop_front();
        checkOutput("pulse_kind", 32'(frame_err), 32'(item.is_err));
        checkOutput("dout", 32'(dout), 32'(item.data));
      end
      if (rx_valid) last_valid_cyc = cyc;
    end
    prev_pulse = rx_valid | frame_err;

    if (gap_counting) begin
      if (!busy_rx) begin
        gap_run++;
      end else begin
        gap_counting = 1'b0;
        gap_done     = 1'b1;
        measured_gap = gap_run;
      end
    end
    if (rx_valid && gap_track && !gap_counting && !gap_done) begin
      gap_counting = 1'b1;
      gap_run      = busy_rx ? 0 : 1;
    end
  end

  initial begin
    repeat (30000) @(posedge fpga_clk);
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'h00, stop_bit: 1'b1, hold_low: 0,  idle_after: 0};
    vecs[1] = '{data: 8'hFF, stop_bit: 1'b1, hold_low: 0,  idle_after: 2 * CPB};
    vecs[2] = '{data: 8'h3C, stop_bit: 1'b0, hold_low: 30, idle_after: 2 * CPB};
    vecs[3] = '{data: 8'h12, stop_bit: 1'b1, hold_low: 0,  idle_after: 0};
    vecs[4] = '{data: 8'hEF, stop_bit: 1'b1, hold_low: 0,  idle_after: 0};
    vecs[5] = '{data: 8'h7E, stop_bit: 1'b1, hold_low: 0,  idle_after: 2 * CPB};

    nrst = 1'b0;
    sin  = 1'b1;
    repeat (3) tick();
    checkOutput("reset_dout", 32'(dout), 32'h00);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_busy", 32'(busy_rx), 32'd0);
    nrst = 1'b1;
    repeat (4) tick();

    // 0xA5 with latency: 2 synchronizer cycles plus HALF + 9*CPB + 1.
    c0 = cyc;
    sb_q.push_back('{is_err: 1'b0, data: 8'hA5});
    last_good = 8'hA5;
    applyStimulus(8'hA5, 1'b1);
    repeat (2 * CPB) tick();
    checkOutput("latency", 32'(last_valid_cyc - c0), 32'(2 + HALF + 9 * CPB + 1));

    // Stop sampled mid-bit leaves CPB-HALF idle cycles before the next start is seen.
    gap_track = 1'b1;
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].stop_bit) begin
        sb_q.push_back('{is_err: 1'b0, data: vecs[v].data});
        last_good = vecs[v].data;
      end else begin
        sb_q.push_back('{is_err: 1'b1, data: last_good});
      end
      applyStimulus(vecs[v].data, vecs[v].stop_bit);
      if (!vecs[v].stop_bit) begin
        repeat (vecs[v].hold_low) tick();
        checkOutput("break_busy", 32'(busy_rx), 32'd1);
        sin = 1'b1;
        repeat (4) tick();
        checkOutput("break_exit", 32'(busy_rx), 32'd0);
        checkOutput("break_dout", 32'(dout), 32'(last_good));
      end
      repeat (vecs[v].idle_after) tick();
    end
    gap_track = 1'b0;
    checkOutput("b2b_idle_gap", 32'(measured_gap), 32'(CPB - HALF));

    // Two-cycle glitch: START is entered, then abandoned at the mid-bit check.
    sin = 1'b0;
    repeat (2) tick();
    sin = 1'b1;
    repeat (2) tick();
    checkOutput("glitch_start_busy", 32'(busy_rx), 32'd1);
    repeat (3 * CPB) tick();
    checkOutput("glitch_busy", 32'(busy_rx), 32'd0);
    checkOutput("glitch_dout", 32'(dout), 32'(last_good));

    // 0x81 interrupted in its fifth data bit; the transmitter resets too, so the line idles.
    sin = 1'b0;
    repeat (CPB) tick();
    for (int i = 7; i >= 4; i--) begin
      sin = (i == 7) ? 1'b1 : 1'b0;
      repeat (CPB) tick();
    end
    sin = 1'b0;
    repeat (HALF) tick();
    nrst = 1'b0;
    sin  = 1'b1;
    tick();
    checkOutput("midrst_dout", 32'(dout), 32'h00);
    checkOutput("midrst_busy", 32'(busy_rx), 32'd0);
    nrst = 1'b1;
    last_good = 8'h00;
    repeat (4 * CPB) tick();
    checkOutput("midrst_dout_hold", 32'(dout), 32'h00);

    sb_q.push_back('{is_err: 1'b0, data: 8'h81});
    last_good = 8'h81;
    applyStimulus(8'h81, 1'b1);
    repeat (2 * CPB) tick();
    checkOutput("final_dout", 32'(dout), 32'h81);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
